// File: rtl/seq_pattern_gen_if.sv
// Control/status bundle between a pattern-generator user (master) and seq_pattern_gen (slave).
// i_hold and its modport entries exist only when SEQ_GEN_HOLD_EN is defined.
interface seq_pattern_gen_if #(
    parameter int DW = 4,
    parameter int LW = 4
) ();
    logic          i_start;
    logic [1:0]    i_mode;
    logic [DW-1:0] i_seed;
    logic [LW-1:0] i_run_len;
    logic [LW-1:0] i_gap_len;
    logic [LW-1:0] i_bursts;
`ifdef SEQ_GEN_HOLD_EN
    logic          i_hold;
`endif
    logic          o_busy;
    logic          o_out_valid;
    logic [DW-1:0] o_data_out;
    logic          o_done;

`ifdef SEQ_GEN_HOLD_EN
    modport master (
        output i_start, i_mode, i_seed, i_run_len, i_gap_len, i_bursts, i_hold,
        input  o_busy, o_out_valid, o_data_out, o_done
    );
    modport slave (
        input  i_start, i_mode, i_seed, i_run_len, i_gap_len, i_bursts, i_hold,
        output o_busy, o_out_valid, o_data_out, o_done
    );
`else
    modport master (
        output i_start, i_mode, i_seed, i_run_len, i_gap_len, i_bursts,
        input  o_busy, o_out_valid, o_data_out, o_done
    );
    modport slave (
        input  i_start, i_mode, i_seed, i_run_len, i_gap_len, i_bursts,
        output o_busy, o_out_valid, o_data_out, o_done
    );
`endif
endinterface

// File: rtl/seq_pattern_gen.sv
// Burst pattern generator (incr/decr/const/LFSR runs separated by idle gaps).
// Optional stall input enabled by defining SEQ_GEN_HOLD_EN.
module seq_pattern_gen #(
    parameter int DW = 4,
    parameter int LW = 4
) (
    input  logic             i_sysclk,
    input  logic             i_rst,
    seq_pattern_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, GAP, FIN} state_t;

    // r_state is the phase of the cycle currently presented on the outputs
    state_t        r_state, w_state_n;
    logic [LW-1:0] r_cnt, w_cnt_n;
    logic [LW-1:0] r_brem, w_brem_n;
    logic [DW-1:0] r_word, w_word_n;
    logic [1:0]    r_mode, w_mode_n;
    logic [LW-1:0] r_run, w_run_n;
    logic [LW-1:0] r_gap, w_gap_n;
    logic          r_busy, r_valid, r_done;
    logic [DW-1:0] r_data;
    logic          w_valid_n, w_end, w_hold;

    function automatic logic [DW-1:0] f_step(input logic [1:0] mode, input logic [DW-1:0] x);
        case (mode)
            2'd0:    f_step = x + 1'b1;
            2'd1:    f_step = x - 1'b1;
            2'd2:    f_step = x;
            default: f_step = {x[DW-2:0], x[DW-1] ^ x[DW-2]};
        endcase
    endfunction

`ifdef SEQ_GEN_HOLD_EN
    assign w_hold = bus.i_hold;
`else
    assign w_hold = 1'b0;
`endif

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_brem_n  = r_brem;
        w_word_n  = r_word;
        w_mode_n  = r_mode;
        w_run_n   = r_run;
        w_gap_n   = r_gap;
        w_valid_n = 1'b0;
        w_end     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.i_start) begin
                    w_mode_n = bus.i_mode;
                    w_run_n  = bus.i_run_len;
                    w_gap_n  = bus.i_gap_len;
                    w_brem_n = (bus.i_bursts == '0) ? LW'(1) : bus.i_bursts;
                    w_word_n = (bus.i_mode == 2'd3 && bus.i_seed == '0) ? DW'(1) : bus.i_seed;
                    if (bus.i_run_len != '0) begin
                        w_state_n = RUN;
                        w_cnt_n   = bus.i_run_len - 1'b1;
                        w_valid_n = 1'b1;
                    end else if (bus.i_gap_len != '0) begin
                        w_state_n = GAP;
                        w_cnt_n   = bus.i_gap_len - 1'b1;
                    end else begin
                        w_state_n = FIN;
                    end
                end
            end
            RUN: begin
                if (!w_hold) begin
                    if (r_cnt != '0) begin
                        w_cnt_n   = r_cnt - 1'b1;
                        w_word_n  = f_step(r_mode, r_word);
                        w_valid_n = 1'b1;
                    end else if (r_gap != '0) begin
                        w_state_n = GAP;
                        w_cnt_n   = r_gap - 1'b1;
                    end else begin
                        w_end = 1'b1;
                    end
                end
            end
            GAP: begin
                if (!w_hold) begin
                    if (r_cnt != '0) w_cnt_n = r_cnt - 1'b1;
                    else             w_end   = 1'b1;
                end
            end
            default: w_state_n = IDLE;
        endcase

        // Burst boundary: the word stream continues from the last emitted word
        if (w_end) begin
            if (r_brem > LW'(1)) begin
                w_brem_n = r_brem - 1'b1;
                if (r_run != '0) begin
                    w_state_n = RUN;
                    w_cnt_n   = r_run - 1'b1;
                    w_word_n  = f_step(r_mode, r_word);
                    w_valid_n = 1'b1;
                end else begin
                    w_state_n = GAP;
                    w_cnt_n   = r_gap - 1'b1;
                end
            end else begin
                w_state_n = FIN;
            end
        end
    end

    always_ff @(posedge i_sysclk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_brem  <= '0;
            r_word  <= '0;
            r_mode  <= '0;
            r_run   <= '0;
            r_gap   <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_brem  <= w_brem_n;
            r_word  <= w_word_n;
            r_mode  <= w_mode_n;
            r_run   <= w_run_n;
            r_gap   <= w_gap_n;
            r_busy  <= (w_state_n != IDLE);
            r_valid <= w_valid_n;
            r_data  <= w_valid_n ? w_word_n : '0;
            r_done  <= (w_state_n == FIN);
        end
    end

    assign bus.o_busy      = r_busy;
    assign bus.o_out_valid = r_valid;
    assign bus.o_data_out  = r_data;
    assign bus.o_done      = r_done;
endmodule

// File: tb/tb_seq_pattern_gen.sv
// Randomized bench for seq_pattern_gen against a queue-based expected-stream model.
module tb_seq_pattern_gen;
    localparam int DW = 4;
    localparam int LW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_pattern_gen_if #(.DW(DW), .LW(LW)) bus ();
    seq_pattern_gen #(.DW(DW), .LW(LW)) dut (.i_sysclk(clk), .i_rst(rst), .bus(bus));

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int step_m(input int mode, input int w);
        int mask = (1 << DW) - 1;
        case (mode)
            0:       return (w + 1) & mask;
            1:       return (w + mask) & mask;
            2:       return w;
            default: return ((w << 1) & mask) | (((w >> (DW - 1)) ^ (w >> (DW - 2))) & 1);
        endcase
    endfunction

    task automatic check_out(input string tag, input int b, input int v, input int d, input int dn);
        chk({tag, ".busy"},  {31'd0, bus.o_busy}, b);
        chk({tag, ".valid"}, {31'd0, bus.o_out_valid}, v);
        chk({tag, ".data"},  {28'd0, bus.o_data_out}, d);
        chk({tag, ".done"},  {31'd0, bus.o_done}, dn);
    endtask

    task automatic set_hold(input bit h);
`ifdef SEQ_GEN_HOLD_EN
        bus.i_hold = h;
`endif
    endtask

    task automatic drive_noise(input bit st);
        bus.i_start   = st;
        bus.i_mode    = 2'($urandom_range(0, 3));
        bus.i_seed    = DW'($urandom);
        bus.i_run_len = LW'($urandom);
        bus.i_gap_len = LW'($urandom);
        bus.i_bursts  = LW'($urandom);
    endtask

    // Expected per-cycle stream after START (busy cycles), computed from the burst rules
    task automatic run_seq(input string tag, input int mode, input int seed, input int run,
                           input int gap, input int bursts, input bit use_hold);
        int qv[$], qd[$], qdn[$];
        int w, nb, p, cyc;
        bit held, h, in_rg;
        w  = (mode == 3 && seed == 0) ? 1 : seed;
        nb = (bursts == 0) ? 1 : bursts;
        for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < run; i++) begin
                qv.push_back(1); qd.push_back(w); qdn.push_back(0);
                w = step_m(mode, w);
            end
            for (int i = 0; i < gap; i++) begin
                qv.push_back(0); qd.push_back(0); qdn.push_back(0);
            end
        end
        qv.push_back(0); qd.push_back(0); qdn.push_back(1);

        @(negedge clk);
        bus.i_start   = 1'b1;
        bus.i_mode    = 2'(mode);
        bus.i_seed    = DW'(seed);
        bus.i_run_len = LW'(run);
        bus.i_gap_len = LW'(gap);
        bus.i_bursts  = LW'(bursts);
        set_hold(use_hold && ($urandom_range(0, 1) == 1));
        p = 0; held = 0; cyc = 0;
        while (p < qv.size() || held) begin
            @(negedge clk);
            cyc++;
            if (cyc > 400) begin
                chk({tag, ".timeout"}, 1, 0);
                break;
            end
            if (held) check_out(tag, 1, 0, 0, 0);
            else      check_out(tag, 1, qv[p], qd[p], qdn[p]);
            drive_noise($urandom_range(0, 1) == 1);
            h = use_hold && ($urandom_range(0, 2) == 0);
            set_hold(h);
            in_rg = held || (p < qv.size() - 1);
            if (!held) p++;
            held = h && in_rg;
        end
        @(negedge clk);
        check_out({tag, ".idle"}, 0, 0, 0, 0);
        bus.i_start = 1'b0;
        set_hold(1'b0);
    endtask

    initial begin
        rst = 1'b1;
        drive_noise(1'b0);
        set_hold(1'b0);
        repeat (2) @(negedge clk);
        check_out("reset", 0, 0, 0, 0);
        rst = 1'b0;
        @(negedge clk);
        check_out("idle0", 0, 0, 0, 0);

        run_seq("t1_incr_wrap", 0, 14, 4, 0, 1, 0);
        run_seq("t2_decr_2b",   1, 1, 3, 2, 2, 0);
        run_seq("t3_lfsr_seed0", 3, 0, 5, 0, 1, 0);
        run_seq("t3_const",     2, 7, 3, 0, 1, 0);
        run_seq("t4_run0",      0, 5, 0, 3, 1, 0);
        run_seq("t4_burst0",    1, 9, 2, 1, 0, 0);
        run_seq("t4_all0",      0, 3, 0, 0, 0, 0);
        run_seq("t4_maxlen",    3, 9, 15, 15, 2, 0);

        // Reset mid-run aborts without DONE; a fresh START restarts from SEED
        @(negedge clk);
        bus.i_start = 1'b1; bus.i_mode = 2'd0; bus.i_seed = 4'd5;
        bus.i_run_len = 4'd8; bus.i_gap_len = 4'd2; bus.i_bursts = 4'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.i_start = 1'b0;
            check_out("t5_prerst", 1, 1, 5 + i, 0);
        end
        rst = 1'b1;
        @(negedge clk);
        check_out("t5_rst", 0, 0, 0, 0);
        rst = 1'b0;
        @(negedge clk);
        check_out("t5_after", 0, 0, 0, 0);
        run_seq("t5_restart", 0, 5, 8, 2, 3, 0);

        for (int k = 0; k < 40; k++) begin
            run_seq($sformatf("rnd%0d", k), $urandom_range(0, 3), $urandom_range(0, 15),
                    $urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(0, 3), 0);
        end
`ifdef SEQ_GEN_HOLD_EN
        for (int k = 0; k < 30; k++) begin
            run_seq($sformatf("hold%0d", k), $urandom_range(0, 3), $urandom_range(0, 15),
                    $urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(0, 3), 1);
        end
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
